// File: rtl/tow_pkg.sv
// Shared constants for the tug-of-war datapath: pushbutton conditioning defaults.
package tow_pkg;

    // Production synchronizer depth, debounce window and counter width.
    localparam int TOW_SYNC_STAGES    = 32'd2;
    localparam int TOW_STABLE_CNT     = 32'd4096;
    localparam int TOW_CNT_W          = 32'd12;

    // Short debounce window so simulations finish in a handful of cycles.
    localparam int TOW_STABLE_CNT_SIM = 32'd4;

endpackage

// File: rtl/pb_conditioner_if.sv
// Pushbutton bundle: raw inputs in, debounced levels and press pulses out.
interface pb_conditioner_if;

    logic pbl_raw;
    logic pbr_raw;
    logic pbl_db;
    logic pbr_db;
    logic pbl_rise;
    logic pbr_rise;

    // Side that owns the buttons and consumes the conditioned signals.
    modport master (
        output pbl_raw,
        output pbr_raw,
        input  pbl_db,
        input  pbr_db,
        input  pbl_rise,
        input  pbr_rise
    );

    // The conditioner itself.
    modport slave (
        input  pbl_raw,
        input  pbr_raw,
        output pbl_db,
        output pbr_db,
        output pbl_rise,
        output pbr_rise
    );

endinterface

// File: rtl/pb_debounce_ch.sv
// One pushbutton channel: synchronizer chain, debounce counter, rising-edge one-shot.
// Reset assumes the button is pressed, so a press only counts after a debounced release.
module pb_debounce_ch
    import tow_pkg::*;
#(
    parameter int SYNC_STAGES = TOW_SYNC_STAGES,   // 2..4
    parameter int STABLE_CNT  = TOW_STABLE_CNT,    // >= 2
    parameter int CNT_W       = TOW_CNT_W          // 2**CNT_W >= STABLE_CNT
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic db,
    output logic rise
);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic [SYNC_STAGES-1:0] sync_r;
    logic [CNT_W-1:0]       cnt_r;
    logic                   db_r;
    logic                   rise_r;

    logic                   sync_s;
    logic [CNT_W-1:0]       cnt_nxt_s;
    logic                   db_nxt_s;
    logic                   rise_nxt_s;

    assign sync_s = sync_r[SYNC_STAGES-1];

    // Plain shift chain into the clock domain; nothing between stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= {SYNC_STAGES{1'b1}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], raw};
        end
    end

    // Debounce decision: count consecutive disagreement, adopt the new level at the window end.
    always_comb begin
        cnt_nxt_s  = cnt_r;
        db_nxt_s   = db_r;
        rise_nxt_s = 1'b0;
        if (sync_s == db_r) begin
            cnt_nxt_s = CNT_ZERO;
        end else if (cnt_r < CNT_MAX) begin
            cnt_nxt_s = cnt_r + CNT_ONE;
        end else begin
            cnt_nxt_s  = CNT_ZERO;
            db_nxt_s   = sync_s;
            rise_nxt_s = sync_s;
        end
    end

    // Debounce state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r  <= CNT_ZERO;
            db_r   <= 1'b1;
            rise_r <= 1'b0;
        end else begin
            cnt_r  <= cnt_nxt_s;
            db_r   <= db_nxt_s;
            rise_r <= rise_nxt_s;
        end
    end

    assign db   = db_r;
    assign rise = rise_r;

endmodule

// File: rtl/pb_conditioner.sv
// Two independent pushbutton channels feeding the tug-of-war game core.
module pb_conditioner
    import tow_pkg::*;
#(
    parameter int SYNC_STAGES = TOW_SYNC_STAGES,
    parameter int STABLE_CNT  = TOW_STABLE_CNT,
    parameter int CNT_W       = TOW_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    pb_conditioner_if.slave    pb
);

    pb_debounce_ch #(
        .SYNC_STAGES (SYNC_STAGES),
        .STABLE_CNT  (STABLE_CNT),
        .CNT_W       (CNT_W)
    ) u_left (
        .clk  (clk),
        .rst  (rst),
        .raw  (pb.pbl_raw),
        .db   (pb.pbl_db),
        .rise (pb.pbl_rise)
    );

    pb_debounce_ch #(
        .SYNC_STAGES (SYNC_STAGES),
        .STABLE_CNT  (STABLE_CNT),
        .CNT_W       (CNT_W)
    ) u_right (
        .clk  (clk),
        .rst  (rst),
        .raw  (pb.pbr_raw),
        .db   (pb.pbr_db),
        .rise (pb.pbr_rise)
    );

endmodule

// File: tb/tb_pb_conditioner.sv
// Self-checking bench for pb_conditioner with the short simulation debounce window.
module tb_pb_conditioner;
    import tow_pkg::*;

    localparam int SS   = TOW_SYNC_STAGES;
    localparam int SC   = TOW_STABLE_CNT_SIM;
    localparam int MAXN = 8192;

    logic clk;
    logic rst;
    pb_conditioner_if pbif ();

    pb_conditioner #(
        .SYNC_STAGES (SS),
        .STABLE_CNT  (SC),
        .CNT_W       (TOW_CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .pb  (pbif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_pass = 0;
    int n_total = 0;

    // Reference model: raw value present at each edge, reset history, db levels.
    bit hist_l [0:MAXN-1];
    bit hist_r [0:MAXN-1];
    int n = 0;
    int last_rst = -1000;
    bit m_db [2];
    bit m_rise [2];
    int since [2];

    // Per-sequence event counters, updated by tick.
    int c_lrise, c_rrise, c_ldb1, t_lrise, t_rrise;

    task automatic chk(input string name, input logic act, input logic exp);
        n_total++;
        if (act !== exp) $display("FAIL %s edge=%0d actual=%b expected=%b", name, n, act, exp);
        else n_pass++;
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_total++;
        if (act != exp) $display("FAIL %s edge=%0d actual=%0d expected=%0d", name, n, act, exp);
        else n_pass++;
    endtask

    // Synchronized value seen by the debouncer at edge k: raw delayed SS edges, 1 after reset.
    function automatic bit m_sync(int ch, int k);
        if (k - SS <= last_rst) return 1'b1;
        return (ch == 0) ? hist_l[k-SS] : hist_r[k-SS];
    endfunction

    // db adopts the synced level once it has disagreed on SC consecutive edges since the last change.
    task automatic model_edge(input bit rst_v);
        bit flip;
        if (rst_v) begin
            last_rst = n;
            for (int ch = 0; ch < 2; ch++) begin
                m_db[ch] = 1'b1; m_rise[ch] = 1'b0; since[ch] = n;
            end
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                flip = (n - since[ch] >= SC);
                for (int k = n - SC + 1; k <= n; k++)
                    if (flip && m_sync(ch, k) == m_db[ch]) flip = 1'b0;
                m_rise[ch] = 1'b0;
                if (flip) begin
                    m_db[ch] = ~m_db[ch];
                    m_rise[ch] = m_db[ch];
                    since[ch] = n;
                end
            end
        end
    endtask

    // Apply inputs, take one clock edge, compare all outputs against the model.
    task automatic tick(input bit rst_v, input bit l, input bit r);
        rst = rst_v;
        pbif.pbl_raw = l;
        pbif.pbr_raw = r;
        hist_l[n+1] = l;
        hist_r[n+1] = r;
        @(posedge clk);
        n++;
        model_edge(rst_v);
        #1;
        chk("pbl_db",   pbif.pbl_db,   m_db[0]);
        chk("pbr_db",   pbif.pbr_db,   m_db[1]);
        chk("pbl_rise", pbif.pbl_rise, m_rise[0]);
        chk("pbr_rise", pbif.pbr_rise, m_rise[1]);
        if (pbif.pbl_rise === 1'b1) begin c_lrise++; t_lrise = n; end
        if (pbif.pbr_rise === 1'b1) begin c_rrise++; t_rrise = n; end
        if (pbif.pbl_db === 1'b1) c_ldb1++;
    endtask

    task automatic clr();
        c_lrise = 0; c_rrise = 0; c_ldb1 = 0; t_lrise = -1; t_rrise = -1;
    endtask

    typedef struct {
        bit rst_v; bit l; bit r;
        bit ldb; bit lrise; bit rdb; bit rrise;
    } vec_t;

    vec_t vecs [15];
    int   edges;

    initial begin
        rst = 1'b1;
        pbif.pbl_raw = 1'b0;
        pbif.pbr_raw = 1'b0;

        // Cases 1 and 2: reset with raw low, debounce to 0, then left press.
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 2; i <= 6; i++)  vecs[i] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 8; i <= 12; i++) vecs[i] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

        for (int i = 0; i < 15; i++) begin
            tick(vecs[i].rst_v, vecs[i].l, vecs[i].r);
            chk("tbl_pbl_db",   pbif.pbl_db,   vecs[i].ldb);
            chk("tbl_pbl_rise", pbif.pbl_rise, vecs[i].lrise);
            chk("tbl_pbr_db",   pbif.pbr_db,   vecs[i].rdb);
            chk("tbl_pbr_rise", pbif.pbr_rise, vecs[i].rrise);
        end

        // Case 5 (release part): left 1->0 falls after SS+SC edges, no pulse.
        clr();
        edges = 0;
        for (int i = 0; i < 20 && pbif.pbl_db === 1'b1; i++) begin
            tick(1'b0, 1'b0, 1'b0);
            edges++;
        end
        chk_int("release_latency", edges, SS + SC);
        chk_int("release_no_pulse", c_lrise, 0);

        // Case 3: bounce 1,0,1,0,1 then 0 never reaches db.
        clr();
        tick(1'b0, 1'b1, 1'b0); tick(1'b0, 1'b0, 1'b0); tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0); tick(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 1'b0);
        chk_int("bounce_db_high", c_ldb1, 0);
        chk_int("bounce_rise", c_lrise, 0);

        // Case 4: both pressed on the same edge, held 100 cycles.
        clr();
        for (int i = 0; i < 100; i++) tick(1'b0, 1'b1, 1'b1);
        chk_int("both_lrise_count", c_lrise, 1);
        chk_int("both_rrise_count", c_rrise, 1);
        chk_int("both_same_cycle", t_lrise, t_rrise);

        // Case 5 (re-press): release then press gives exactly one new left pulse.
        clr();
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 1'b1);
        chk("release_db", pbif.pbl_db, 1'b0);
        chk_int("release_rise", c_lrise, 0);
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b1, 1'b1);
        chk_int("repress_rise", c_lrise, 1);
        chk_int("right_held_no_rise", c_rrise, 0);

        // Case 6: held through reset mid-count.
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 1'b0);
        chk("pre6_db", pbif.pbl_db, 1'b0);
        for (int i = 0; i < SS + 2; i++) tick(1'b0, 1'b1, 1'b0);
        chk("midcount_db", pbif.pbl_db, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        chk("rst_db", pbif.pbl_db, 1'b1);
        chk("rst_rise", pbif.pbl_rise, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        chk("post_rst_rise", pbif.pbl_rise, 1'b0);
        clr();
        for (int i = 0; i < 20; i++) tick(1'b0, 1'b1, 1'b0);
        chk_int("held_rst_rise", c_lrise, 0);
        chk_int("held_rst_db", c_ldb1, 20);
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b1, 1'b0);
        chk_int("after_release_press", c_lrise, 1);

        // Randomized phase: independent bursty channels, occasional reset, all against the model.
        begin
            int hl, hr;
            bit vl, vr;
            hl = 0; hr = 0; vl = 1'b0; vr = 1'b0;
            for (int i = 0; i < 1500; i++) begin
                if (hl == 0) begin vl = 1'($urandom_range(0, 1)); hl = $urandom_range(1, 8); end
                if (hr == 0) begin vr = 1'($urandom_range(0, 1)); hr = $urandom_range(1, 8); end
                hl--; hr--;
                tick($urandom_range(0, 199) == 0, vl, vr);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pb_conditioner.md
Name: pb_conditioner

Overview:
- Upstream input stage of the tug-of-war datapath: takes the two raw, asynchronous player pushbuttons and produces clean signals for the round/scoring logic.
- Per channel: synchronizer, debounce counter and rising-edge one-shot.
- Outputs pbl_rise/pbr_rise feed the pbl/pbr inputs of the game core; levels pbl_db/pbr_db are exported for tie/hold checks.
- Runs on the divided game clock.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops per channel; legal range 2..4.
- STABLE_CNT, 4096, cycles a synchronized input must differ from the debounced level before the level changes; must be >= 2.
- CNT_W, 12, debounce counter width; must satisfy 2^CNT_W >= STABLE_CNT.

Ports:
- clk  in  1  game clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- pbl_raw  in  1  left button, active-high, asynchronous.
- pbr_raw  in  1  right button, active-high, asynchronous.
- pbl_db  out  1  debounced left level.
- pbr_db  out  1  debounced right level.
- pbl_rise  out  1  one-cycle pulse on debounced left press.
- pbr_rise  out  1  one-cycle pulse on debounced right press.

Behaviour:
- Reset (rst=1 at a clk edge):
  - all synchronizer flops <= 1; db <= 1 ("assume pressed"); counter <= 0; rise <= 0.
  - Consequence: a button held through reset never produces a pulse; a press counts only after a debounced release.
- Synchronizer: SYNC_STAGES-flop shift chain per channel; sync = last stage. No logic between stages.
- Debounce, per channel, each edge with rst=0:
  - sync == db: counter <= 0.
  - sync != db and counter < STABLE_CNT-1: counter <= counter+1.
  - sync != db and counter == STABLE_CNT-1: db <= sync, counter <= 0.
  - Any glitch shorter than STABLE_CNT cycles resets the counter, so db is unchanged.
  - The counter never wraps.
- Latency: a clean raw transition reaches db after SYNC_STAGES+STABLE_CNT edges (±1 for asynchronous sampling).
- Rise pulse:
  - rise <= 1 at the same edge db goes 0->1; otherwise rise <= 0.
  - Exactly one cycle high per debounced press.
  - No pulse on release (1->0).
  - No pulse while held, however long.
- Channels are fully independent. Both rise pulses in the same cycle is legal and passes through unchanged; tie resolution belongs downstream.
- Reset mid-debounce discards the count and forces db=1, with no pulse in the reset cycle or the cycle after.
- No combinational path from any input to any output; all outputs are registered.

Decomposition:
- Shared package tow_pkg holds:
  - default constants TOW_SYNC_STAGES=2, TOW_STABLE_CNT=4096, TOW_CNT_W=12;
  - a sim-override constant TOW_STABLE_CNT_SIM=4.
- Sub-module pb_debounce_ch, one channel: ports clk, rst, raw, db, rise, with the same parameters.
  - Instantiated twice, for left and right.
  - pb_conditioner is wiring only.

Test Plan (STABLE_CNT=4, SYNC_STAGES=2):
1. Reset with both raw=0, release rst, hold raw=0 → after 2+4 edges pbl_db=pbr_db=0; pbl_rise and pbr_rise stay 0 throughout.
2. From case 1, pbl_raw=1 held → pbl_db=1 on the 6th edge after the raw change, pbl_rise=1 for exactly that one cycle, pbr_* unchanged.
3. Bounce: pbl_raw pattern 1,0,1,0,1 (one cycle each) then 0 → pbl_db stays 0, pbl_rise never asserts.
4. Both raw 0->1 on the same edge → pbl_rise and pbr_rise both assert in the same single cycle; held 100 cycles → no further pulses.
5. Release: pbl_raw 1->0 held → pbl_db falls after 6 edges with no pulse; re-press → one new pbl_rise.
6. Held through reset: pbl_raw=1, assert rst mid-count (counter=2), release → pbl_db=1 immediately, no pbl_rise until a debounced release and press.
